// File: rtl/piezo_alert_sched.sv
// Alert scheduler for the piezo tone generator: arbitrates charge / too-fast / low-battery
// tunes and feeds them note by note over a valid/ready command handshake.
module piezo_alert_sched #(
  parameter bit fast_sim   = 1'b1,
  parameter int REPEAT_CYC = 150_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_steer,
  input  logic       too_fast,
  input  logic       batt_low,
  input  logic       note_rdy,
  input  logic       note_done,
  output logic       note_vld,
  output logic [1:0] note_id,
  output logic [1:0] note_dur,
  output logic       abort,
  output logic       busy,
  output logic [1:0] active_tune
);

  typedef enum logic [1:0] {IDLE, ISSUE, PLAY, ABORT} state_t;

  localparam logic [1:0]  T_NONE = 2'd0;
  localparam logic [1:0]  T_CHG  = 2'd1;
  localparam logic [1:0]  T_FAST = 2'd2;
  localparam logic [1:0]  T_BATT = 2'd3;
  localparam logic [28:0] RPT_LIM  = 29'(REPEAT_CYC);
  localparam logic [28:0] RPT_STEP = fast_sim ? 29'd64 : 29'd1;

  function automatic logic [1:0] rank(input logic [1:0] tune);
    case (tune)
      T_FAST:  rank = 2'd3;
      T_BATT:  rank = 2'd2;
      T_CHG:   rank = 2'd1;
      default: rank = 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] tune);
    last_idx = (tune == T_FAST) ? 3'd2 : 3'd5;
  endfunction

  // Returns {note_id, note_dur}; FAST reuses the first three CHARGE notes.
  function automatic logic [3:0] note_lut(input logic [1:0] tune, input logic [2:0] idx);
    note_lut = 4'h0;
    if (tune == T_BATT) begin
      case (idx)
        3'd0:    note_lut = {2'd3, 2'd3};
        3'd1:    note_lut = {2'd2, 2'd0};
        3'd2:    note_lut = {2'd3, 2'd2};
        3'd3:    note_lut = {2'd2, 2'd1};
        3'd4:    note_lut = {2'd1, 2'd1};
        default: note_lut = {2'd0, 2'd1};
      endcase
    end else begin
      case (idx)
        3'd0:    note_lut = {2'd0, 2'd1};
        3'd1:    note_lut = {2'd1, 2'd1};
        3'd2:    note_lut = {2'd2, 2'd1};
        3'd3:    note_lut = {2'd3, 2'd2};
        3'd4:    note_lut = {2'd2, 2'd0};
        default: note_lut = {2'd3, 2'd3};
      endcase
    end
  endfunction

  state_t      state, state_nx;
  logic [1:0]  tune_nx, pend, pend_nx, req_tune;
  logic [2:0]  idx, idx_nx;
  logic        abort_nx, start, preempt, cancel;
  logic        req_fast, req_batt, req_chg;
  logic [27:0] rpt_cnt;
  logic [28:0] rpt_sum;
  logic        rpt_exp;

  assign req_fast = en_steer & too_fast;
  assign req_batt = batt_low & rpt_exp;
  assign req_chg  = en_steer & ~batt_low & rpt_exp;
  assign req_tune = req_fast ? T_FAST : req_batt ? T_BATT : req_chg ? T_CHG : T_NONE;
  assign preempt  = rank(req_tune) > rank(active_tune);
  assign cancel   = ((active_tune == T_CHG) || (active_tune == T_FAST)) && !en_steer;
  assign rpt_sum  = {1'b0, rpt_cnt} + RPT_STEP;

  always_comb begin
    state_nx = state;
    tune_nx  = active_tune;
    idx_nx   = idx;
    pend_nx  = pend;
    abort_nx = 1'b0;
    start    = 1'b0;
    case (state)
      IDLE: begin
        if (req_tune != T_NONE) begin
          tune_nx  = req_tune;
          idx_nx   = 3'd0;
          state_nx = ISSUE;
          start    = (req_tune == T_CHG) || (req_tune == T_BATT);
        end
      end
      ISSUE, PLAY: begin
        // Preemption beats everything, including a note_done landing in the same cycle.
        if (preempt) begin
          pend_nx  = req_tune;
          abort_nx = 1'b1;
          state_nx = ABORT;
          start    = (req_tune == T_CHG) || (req_tune == T_BATT);
        end else if (cancel) begin
          pend_nx  = T_NONE;
          abort_nx = 1'b1;
          state_nx = ABORT;
        end else if (state == ISSUE) begin
          if (note_rdy) state_nx = PLAY;
        end else if (note_done) begin
          if (idx != last_idx(active_tune)) begin
            idx_nx   = idx + 3'd1;
            state_nx = ISSUE;
          end else if ((active_tune == T_FAST) && req_fast) begin
            idx_nx   = 3'd0;
            state_nx = ISSUE;
          end else begin
            tune_nx  = T_NONE;
            state_nx = IDLE;
          end
        end
      end
      default: begin
        if (pend == T_NONE) begin
          tune_nx  = T_NONE;
          state_nx = IDLE;
        end else begin
          tune_nx  = pend;
          idx_nx   = 3'd0;
          state_nx = ISSUE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 3'd0;
      pend        <= T_NONE;
      active_tune <= T_NONE;
      note_vld    <= 1'b0;
      note_id     <= 2'd0;
      note_dur    <= 2'd0;
      abort       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      pend        <= pend_nx;
      active_tune <= tune_nx;
      note_vld    <= (state_nx == ISSUE);
      abort       <= abort_nx;
      busy        <= (state_nx != IDLE);
      if (state_nx == ISSUE) {note_id, note_dur} <= note_lut(tune_nx, idx_nx);
    end
  end

  // Repeat timer: frozen while CHARGE or BATT plays, saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt <= 28'd0;
      rpt_exp <= 1'b1;
    end else if (start) begin
      rpt_cnt <= 28'd0;
      rpt_exp <= 1'b0;
    end else begin
      if ((active_tune != T_CHG) && (active_tune != T_BATT))
        rpt_cnt <= (rpt_sum >= RPT_LIM) ? RPT_LIM[27:0] : rpt_sum[27:0];
      if ({1'b0, rpt_cnt} >= RPT_LIM) rpt_exp <= 1'b1;
    end
  end

endmodule
